sbmips_stack_ctrl: RTL and testbench

//  Sequences the operand stack of the stack-based MIPS core. Takes push, pop and
//  top-of-stack (peek) commands from the control unit and runs them against a

---
 rtl/sbmips_stack_ctrl_if.sv | 19 +
 rtl/sbmips_stack_ctrl.sv | 69 ++++++
 tb/tb_sbmips_stack_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sbmips_stack_ctrl_if.sv
// sbmips_stack_ctrl_if: command, status and stack RAM signals of the operand stack controller
interface sbmips_stack_ctrl_if #(parameter int DATA_W = 8, parameter int ADDR_W = 5);
  logic push, pop, tos, err_clr;
  logic [DATA_W-1:0] din, dout, ram_wdata, ram_rdata;
  logic ready, dout_valid, empty, full, overflow, underflow;
  logic [ADDR_W:0] sp;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we, ram_re;
  modport master (
    output push, pop, tos, din, err_clr, ram_rdata,
    input  ready, dout, dout_valid, empty, full, sp, overflow, underflow,
    input  ram_addr, ram_wdata, ram_we, ram_re
  );
  modport slave (
    input  push, pop, tos, din, err_clr, ram_rdata,
    output ready, dout, dout_valid, empty, full, sp, overflow, underflow,
    output ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/sbmips_stack_ctrl.sv
// sbmips_stack_ctrl: push/pop/tos sequencer for a single-port synchronous stack RAM
module sbmips_stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input logic clk,
  input logic rst,
  sbmips_stack_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_t;
  state_t state, nxt;
  logic [ADDR_W:0] sp, sp_m1;
  logic [DATA_W-1:0] wbuf, dout;
  logic dout_valid, overflow, underflow, is_pop;
  logic idle, sel_pop, sel_push, sel_tos, empty, full, rd_go, wr_go;
  assign idle     = state == IDLE;
  assign sel_pop  = idle & bus.pop;
  assign sel_push = idle & !bus.pop & bus.push;
  assign sel_tos  = idle & !bus.pop & !bus.push & bus.tos;
  assign empty    = sp == '0;
  assign full     = sp == (ADDR_W+1)'(DEPTH);
  assign sp_m1    = sp - 1'b1;
  assign rd_go    = (sel_pop | sel_tos) & !empty;
  assign wr_go    = sel_push & !full;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = rd_go ? RD : wr_go ? WR : IDLE;
      RD:      nxt = RWAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sp         <= '0;
      wbuf       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      is_pop     <= 1'b0;
    end else begin
      dout_valid <= state == RWAIT;
      if (state == RWAIT) dout <= bus.ram_rdata;
      if (wr_go) wbuf <= bus.din;
      if (rd_go) is_pop <= sel_pop;
      if (state == WR) sp <= sp + 1'b1;
      else if (state == RD && is_pop) sp <= sp_m1;
      // a clear wins over a flag raised on the same edge
      overflow  <= !bus.err_clr & (overflow | (sel_push & full));
      underflow <= !bus.err_clr & (underflow | ((sel_pop | sel_tos) & empty));
    end
  assign bus.ready      = idle;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.sp         = sp;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.overflow   = overflow;
  assign bus.underflow  = underflow;
  assign bus.ram_we     = state == WR;
  assign bus.ram_re     = state == RD;
  assign bus.ram_addr   = state == WR ? sp[ADDR_W-1:0] : state == RD ? sp_m1[ADDR_W-1:0] : '0;
  assign bus.ram_wdata  = state == WR ? wbuf : '0;
endmodule

// File: tb/tb_sbmips_stack_ctrl.sv
// tb_sbmips_stack_ctrl: directed and model-checked random test of the stack controller
module tb_sbmips_stack_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  sbmips_stack_ctrl_if #(.DATA_W(8), .ADDR_W(5)) bus();
  sbmips_stack_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] mem [32];
  logic [7:0] rdata = 8'h00;
  int we_cnt = 0;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) rdata <= mem[bus.ram_addr];
    if (bus.ram_we) we_cnt <= we_cnt + 1;
  end
  assign bus.ram_rdata = rdata;
  int total = 0, bad = 0, we0;
  int m_sp, m_ph;
  logic m_ispop, m_of, m_uf, m_valid;
  logic [7:0] m_wd, m_rd, m_dout;
  logic [7:0] stk [32];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_chk(input logic [7:0] d, input int addr);
    bus.push = 1'b1;
    bus.din  = d;
    tick();
    bus.push = 1'b0;
    chk("push_we", bus.ram_we, 1);
    chk("push_addr", bus.ram_addr, addr);
    chk("push_wdata", bus.ram_wdata, d);
    chk("push_busy", bus.ready, 0);
    tick();
    chk("push_sp", bus.sp, addr + 1);
    chk("push_we_off", bus.ram_we, 0);
  endtask
  task automatic rd_chk(input logic is_pop, input logic [7:0] exp, input int exp_sp);
    if (is_pop) bus.pop = 1'b1;
    else bus.tos = 1'b1;
    tick();
    bus.pop = 1'b0;
    bus.tos = 1'b0;
    chk("rd_re", bus.ram_re, 1);
    chk("rd_addr", bus.ram_addr, (is_pop ? exp_sp : exp_sp - 1) & 31);
    tick();
    chk("rd_early_valid", bus.dout_valid, 0);
    chk("rd_sp", bus.sp, exp_sp);
    tick();
    chk("rd_valid", bus.dout_valid, 1);
    chk("rd_dout", bus.dout, exp);
    chk("rd_ready", bus.ready, 1);
    tick();
    chk("rd_pulse", bus.dout_valid, 0);
    chk("rd_hold", bus.dout, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.tos = 1'b0;
    bus.err_clr = 1'b0;
    bus.din = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    tick();
    tick();
    chk("rst_sp", bus.sp, 0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_flags", {bus.overflow, bus.underflow}, 0);
    chk("rst_ram", {bus.ram_we, bus.ram_re}, 0);
    rst = 1'b0;
    tick();
    we0 = we_cnt;
    push_chk(8'h11, 0);
    push_chk(8'h22, 1);
    push_chk(8'h33, 2);
    chk("we_count", we_cnt - we0, 3);
    chk("mem0", mem[0], 8'h11);
    chk("mem1", mem[1], 8'h22);
    chk("mem2", mem[2], 8'h33);
    rd_chk(1'b0, 8'h33, 3);
    rd_chk(1'b1, 8'h33, 2);
    rd_chk(1'b1, 8'h22, 1);
    for (int i = 1; i < 32; i++) push_chk(8'(i), i);
    chk("fill_full", bus.full, 1);
    chk("fill_sp", bus.sp, 32);
    bus.push = 1'b1;
    bus.din = 8'hAA;
    tick();
    bus.push = 1'b0;
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_ready", bus.ready, 1);
    chk("ovf_we", bus.ram_we, 0);
    tick();
    chk("ovf_sp", bus.sp, 32);
    chk("ovf_we2", bus.ram_we, 0);
    chk("ovf_mem31", mem[31], 8'd31);
    chk("ovf_mem0", mem[0], 8'h11);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ovf_clr", bus.overflow, 0);
    for (int i = 31; i >= 1; i--) rd_chk(1'b1, 8'(i), i);
    bus.pop = 1'b1;
    bus.push = 1'b1;
    bus.din = 8'h99;
    tick();
    bus.pop = 1'b0;
    bus.push = 1'b0;
    chk("prio_re", bus.ram_re, 1);
    chk("prio_we", bus.ram_we, 0);
    tick();
    chk("prio_we2", bus.ram_we, 0);
    tick();
    chk("prio_dout", bus.dout, 8'h11);
    chk("prio_valid", bus.dout_valid, 1);
    chk("prio_sp", bus.sp, 0);
    chk("prio_empty", bus.empty, 1);
    chk("prio_mem1", mem[1], 8'd1);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("udf_flag", bus.underflow, 1);
    chk("udf_ready", bus.ready, 1);
    chk("udf_re", bus.ram_re, 0);
    tick();
    chk("udf_valid", bus.dout_valid, 0);
    chk("udf_re2", bus.ram_re, 0);
    chk("udf_dout", bus.dout, 8'h11);
    push_chk(8'h77, 0);
    bus.push = 1'b1;
    bus.din = 8'hEE;
    tick();
    bus.push = 1'b0;
    chk("mid_we", bus.ram_we, 1);
    rst = 1'b1;
    #1;
    chk("arst_we", bus.ram_we, 0);
    chk("arst_sp", bus.sp, 0);
    chk("arst_ready", bus.ready, 1);
    chk("arst_flags", {bus.overflow, bus.underflow}, 0);
    tick();
    rst = 1'b0;
    push_chk(8'h55, 0);
    chk("arst_mem0", mem[0], 8'h55);
    chk("arst_mem1", mem[1], 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_sp = 0;
    m_ph = 0;
    m_ispop = 1'b0;
    m_of = 1'b0;
    m_uf = 1'b0;
    m_valid = 1'b0;
    m_dout = 8'h00;
    m_wd = 8'h00;
    m_rd = 8'h00;
    for (int c = 0; c < 200; c++) begin
      bus.push = $urandom_range(0, 99) < (c < 100 ? 70 : 30);
      bus.pop = $urandom_range(0, 5) < (c < 100 ? 1 : 3);
      bus.tos = $urandom_range(0, 3) == 0;
      bus.din = 8'($urandom);
      bus.err_clr = $urandom_range(0, 15) == 0;
      m_valid = 1'b0;
      case (m_ph)
        0: if (bus.pop) begin
             if (m_sp == 0) m_uf = 1'b1;
             else begin m_ph = 2; m_ispop = 1'b1; end
           end else if (bus.push) begin
             if (m_sp == 32) m_of = 1'b1;
             else begin m_ph = 1; m_wd = bus.din; end
           end else if (bus.tos) begin
             if (m_sp == 0) m_uf = 1'b1;
             else begin m_ph = 2; m_ispop = 1'b0; end
           end
        1: begin stk[m_sp] = m_wd; m_sp++; m_ph = 0; end
        2: begin m_rd = stk[m_sp-1]; if (m_ispop) m_sp--; m_ph = 3; end
        default: begin m_dout = m_rd; m_valid = 1'b1; m_ph = 0; end
      endcase
      if (bus.err_clr) begin m_of = 1'b0; m_uf = 1'b0; end
      tick();
      chk("rnd_dout", bus.dout, m_dout);
      chk("rnd_valid", bus.dout_valid, m_valid);
      chk("rnd_sp", bus.sp, m_sp);
      chk("rnd_full", bus.full, m_sp == 32);
      chk("rnd_empty", bus.empty, m_sp == 0);
      chk("rnd_ovf", bus.overflow, m_of);
      chk("rnd_udf", bus.underflow, m_uf);
      chk("rnd_ready", bus.ready, m_ph == 0);
    end
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.tos = 1'b0;
    bus.err_clr = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
